// File: rtl/multu_hilo_unit_pkg.sv
// Shared definitions for the shift-add MULTU unit: function codes from ALU control,
// FSM state encoding and the default operand width.
package multu_hilo_unit_pkg;

  localparam int MUL_WIDTH = 32;

  localparam logic [5:0] MULTU        = 6'd25;
  localparam logic [5:0] MFHI         = 6'd16;
  localparam logic [5:0] MFLO         = 6'd18;
  localparam logic [5:0] SIG_MUL_DONE = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/multu_hilo_unit_hilo_regs.sv
// Architectural HI/LO register pair with a product write port and the MFHI/MFLO read mux.
module hilo_regs
  import multu_hilo_unit_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [2*WIDTH-1:0] prod,
  input  logic [5:0]         sig,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   dataOut
);

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (we) begin
      hi <= prod[2*WIDTH-1:WIDTH];
      lo <= prod[WIDTH-1:0];
    end
  end

  always_comb begin
    dataOut = '0;
    case (sig)
      MFHI:    dataOut = hi;
      MFLO:    dataOut = lo;
      default: dataOut = '0;
    endcase
  end

endmodule

// File: rtl/multu_hilo_unit.sv
// Sequential unsigned multiplier: one multiplier bit per clock, result lands in HI/LO
// on the final iteration edge, followed by a one-cycle done pulse.
module multu_hilo_unit
  import multu_hilo_unit_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mul_state_e         state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic               abort;
  logic               hilo_we;

  assign prod_nxt = mplier[0] ? (prod + mcand) : prod;
  // Only the completion code keeps a running multiply alive besides MULTU itself.
  assign abort    = (Signal != MULTU) && (Signal != SIG_MUL_DONE);
  assign hilo_we  = (state == ST_RUN) && !abort && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (Signal == MULTU) begin
            mcand  <= {{WIDTH{1'b0}}, dataA};
            mplier <= dataB;
            prod   <= '0;
            count  <= '0;
            state  <= ST_RUN;
            busy   <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (count == LAST) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  hilo_regs #(.WIDTH(WIDTH)) u_hilo (
    .clk     (clk),
    .reset   (reset),
    .we      (hilo_we),
    .prod    (prod_nxt),
    .sig     (Signal),
    .hi      (hi),
    .lo      (lo),
    .dataOut (dataOut)
  );

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit with hand-computed products and cycle-exact done timing.
module tb_multu_hilo_unit;

  localparam logic [5:0] C_MULTU = 6'd25;
  localparam logic [5:0] C_MFHI  = 6'd16;
  localparam logic [5:0] C_MFLO  = 6'd18;
  localparam logic [5:0] C_FIN   = 6'b111111;
  localparam logic [5:0] C_ADD   = 6'b100000;
  localparam logic [5:0] C_NOP   = 6'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Signal;
  logic [31:0] dataA, dataB;
  logic [31:0] dataOut, hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  multu_hilo_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .Signal  (Signal),
    .dataA   (dataA),
    .dataB   (dataB),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Capture at E0, MULTU held through E31, completion code at E32; checks busy/done timing.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int busy_cyc;
    int early_done;
    busy_cyc   = 0;
    early_done = 0;
    dataA  = a;
    dataB  = b;
    Signal = C_MULTU;
    step();
    for (int i = 1; i <= 32; i++) begin
      Signal = (i <= 31) ? C_MULTU : C_FIN;
      if (busy) busy_cyc++;
      if (done) early_done++;
      step();
    end
    chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd32);
    chk({tag, "_early_done"}, 64'(early_done), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    Signal = C_NOP;
    step();
    chk({tag, "_done_clr"}, 64'(done), 64'd0);
  endtask

  initial begin
    int seen_done;
    reset  = 1'b1;
    Signal = C_NOP;
    dataA  = '0;
    dataB  = '0;
    step();
    step();
    reset = 1'b0;
    Signal = C_MFHI;
    #1;
    chk("rst_mfhi", 64'(dataOut), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    Signal = C_MFLO;
    #1;
    chk("rst_mflo", 64'(dataOut), 64'd0);

    run_mul(32'd7, 32'd6, 32'd0, 32'd42, "m7x6");

    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "mmax");
    Signal = C_MFHI;
    #1;
    chk("mmax_mfhi", 64'(dataOut), 64'hFFFFFFFE);
    Signal = C_MFLO;
    #1;
    chk("mmax_mflo", 64'(dataOut), 64'h00000001);
    Signal = C_ADD;
    #1;
    chk("other_sig_out", 64'(dataOut), 64'd0);

    // Abort after 10 RUN cycles
    dataA  = 32'd3;
    dataB  = 32'd5;
    Signal = C_MULTU;
    step();
    for (int i = 0; i < 10; i++) step();
    chk("abort_busy_pre", 64'(busy), 64'd1);
    Signal = C_MFLO;
    #1;
    chk("abort_mflo_run", 64'(dataOut), 64'h00000001);
    Signal = C_ADD;
    step();
    chk("abort_busy", 64'(busy), 64'd0);
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) seen_done++;
      step();
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);
    chk("abort_hi", 64'(hi), 64'hFFFFFFFE);
    chk("abort_lo", 64'(lo), 64'h00000001);

    // Reset during RUN cycle 20
    dataA  = 32'd12345;
    dataB  = 32'd678;
    Signal = C_MULTU;
    step();
    for (int i = 0; i < 19; i++) step();
    chk("rrun_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    reset  = 1'b0;
    Signal = C_MFHI;
    #1;
    chk("rrun_hi", 64'(hi), 64'd0);
    chk("rrun_lo", 64'(lo), 64'd0);
    chk("rrun_busy0", 64'(busy), 64'd0);
    chk("rrun_done0", 64'(done), 64'd0);
    chk("rrun_out", 64'(dataOut), 64'd0);
    run_mul(32'd12345, 32'd678, 32'd0, 32'd8369910, "m12345");

    // Back-to-back: 2x3 then 2x9, dataA disturbed during each run
    dataA  = 32'd2;
    dataB  = 32'd3;
    Signal = C_MULTU;
    step();
    for (int i = 1; i <= 32; i++) begin
      if (i == 5) dataA = 32'd100;
      step();
    end
    chk("b2b_done1", 64'(done), 64'd1);
    chk("b2b_lo1", 64'(lo), 64'd6);
    dataA = 32'd2;
    dataB = 32'd9;
    step();
    chk("b2b_busy2", 64'(busy), 64'd1);
    chk("b2b_done_clr", 64'(done), 64'd0);
    Signal = C_MFLO;
    #1;
    chk("b2b_mflo_run", 64'(dataOut), 64'd6);
    Signal = C_MULTU;
    for (int i = 1; i <= 32; i++) begin
      if (i == 3) dataA = 32'd55;
      step();
    end
    chk("b2b_done2", 64'(done), 64'd1);
    chk("b2b_lo2", 64'(lo), 64'd18);
    chk("b2b_hi2", 64'(hi), 64'd0);
    Signal = C_NOP;
    step();
    chk("b2b_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multu_hilo_unit.md
Name: multu_hilo_unit

Overview:
- Sequential shift-add unsigned multiplier that consumes the 6-bit function code produced by the ALU control stage (SignaltoMUL).
- Holds the architectural HI/LO register pair.
- Serves MFHI/MFLO reads onto the datapath result mux.
- One multiplier bit per clock: a 32x32 MULTU completes in 32 iteration cycles after operand capture.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits, iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk
- Signal  input  6  function code from ALU control (MULTU=25, MFHI=16, MFLO=18, completion code 6'b111111, others ignored)
- dataA  input  WIDTH  multiplicand (rs), sampled only on operand capture
- dataB  input  WIDTH  multiplier (rt), sampled only on operand capture
- dataOut  output  WIDTH  HI when Signal==MFHI, LO when Signal==MFLO, else 0 (combinational from registered HI/LO)
- busy  output  1  high in RUN state
- done  output  1  one-cycle pulse in DONE state; HI/LO already hold the new product
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (reset==1 at a clk edge): state=IDLE, count=0, multiplicand/multiplier/product regs=0, hi=0, lo=0, busy=0, done=0. Reset wins over every other event, including mid-RUN; a partial product is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - Signal==MULTU at an edge: capture mcand=dataA (zero-extended to 2*WIDTH), mplier=dataB, prod=0, count=0; go to RUN.
  - Any other Signal: stay in IDLE.
- RUN, each edge:
  - If mplier[0], prod = prod + mcand (2*WIDTH-bit add, no overflow possible).
  - Then mcand <<= 1, mplier >>= 1, count += 1.
  - When count reaches WIDTH-1 on this edge (the WIDTH-th iteration): write hi=final prod[2W-1:W], lo=final prod[W-1:0] at this same edge, go to DONE.
- Abort: in RUN, if Signal is neither MULTU nor 6'b111111, go to IDLE at that edge. hi/lo unchanged, no done pulse. The completion code 6'b111111 never aborts; completion is governed solely by the internal count.
- DONE:
  - done=1 for exactly one cycle.
  - If Signal==MULTU at this edge: capture new operands and go to RUN (back-to-back multiply).
  - Otherwise go to IDLE.
- Latency: first MULTU sampled at edge E0; hi/lo and done valid after edge E0+32 (WIDTH+1 edges incl. capture).
- Operands are captured once. Changes to dataA/dataB during RUN have no effect.
- MFHI/MFLO are served in any state and return current hi/lo. During RUN they return the previous product.
- count width is clog2(WIDTH) bits; it never wraps in normal flow and is cleared on capture.
- Signal values other than MULTU/MFHI/MFLO in IDLE leave all state unchanged; dataOut=0.

Decomposition:
- Shared package:
  - function-code constants MULTU, MFHI, MFLO, SIG_MUL_DONE=6'b111111 (shared with ALU control)
  - state encoding IDLE/RUN/DONE
  - WIDTH default
- One natural sub-module: hilo_regs. It holds the 2xWIDTH register pair with synchronous reset, a write-enable/product input, and the MFHI/MFLO read mux. The FSM and shift-add datapath stay in the top.

Test Plan:
- Reset then MFHI/MFLO -> dataOut=0 both; busy=0, done=0.
- dataA=32'd7, dataB=32'd6, Signal=MULTU held 31 cycles then 6'b111111 -> done pulses once 32 edges after capture; hi=0, lo=42; busy high for exactly 32 cycles.
- dataA=dataB=32'hFFFFFFFF, MULTU -> hi=32'hFFFFFFFE, lo=32'h00000001; then Signal=MFHI -> dataOut=32'hFFFFFFFE; Signal=MFLO -> dataOut=32'h00000001.
- Start MULTU 3x5, switch Signal to ADD (6'b100000) after 10 RUN cycles -> state IDLE, no done, hi/lo keep prior 0xFFFFFFFE/0x00000001.
- Assert reset at RUN cycle 20 of 12345x678 -> next cycle all outputs 0; a fresh MULTU afterwards yields lo=8369910, hi=0.
- Back-to-back: MULTU 2x3 with Signal returning to MULTU during DONE; dataB changed to 9 in the DONE cycle (dataA stays 2) -> lo=6 after the first done pulse, then lo=18 after 32 more edges; changing dataA during RUN does not alter the result.
